// File: rtl/fifo_drain_uart_tx_pkg.sv
// Shared types for the FIFO-draining UART transmitter.
// Holds the frame FSM states and parity-mode codes.
package fifo_drain_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..DIV-1 and ticks on the last count.
// A restart forces the count back to zero for the next cycle.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_drain_uart_tx.sv
// UART transmitter that pops bytes from a FWFT FIFO and sends them
// back to back as 8N1 or 8E1/8O1 frames.
module fifo_drain_uart_tx
  import fifo_drain_uart_tx_pkg::*;
#(
  parameter int CLOCK_FREQ = 62500000,
  parameter int BAUD       = 115200,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_deq,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int DIV = CLOCK_FREQ / BAUD;

  if (DIV < 2) begin : g_div_chk
    $error("fifo_drain_uart_tx: CLOCK_FREQ/BAUD must be >= 2");
  end

  state_e     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       tick;
  logic       load;
  logic       restart;
  logic       par_bit;

  // A new word may be taken only from IDLE or the final STOP cycle.
  assign load = enable && !fifo_empty && !rst &&
                ((state_q == IDLE) ||
                 ((state_q == STOP) && tick));

  assign restart = load || (state_q == IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    if (load) data_d = fifo_dout;
    unique case (state_q)
      IDLE: if (load) state_d = START;
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR:  if (tick) state_d = STOP;
      STOP: if (tick) state_d = load ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is computed from next-state values so the line is a flop output.
  always_comb begin
    par_bit = (^data_d) ^ (PARITY == PAR_ODD);
    tx_d    = 1'b1;
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PAR:     tx_d = par_bit;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign fifo_deq   = load;
  assign frame_done = (state_q == STOP) && tick;
  assign tx         = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_drain_uart_tx.sv
// Directed bench for fifo_drain_uart_tx at DIV=4.
// Three instances cover no, even and odd parity.
module tb_fifo_drain_uart_tx;

  localparam int CF = 460800;
  localparam int BR = 115200;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       deq0, deq1, deq2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       fd0, fd1, fd2;

  logic       deq_s, tx_s, busy_s, fd_s;
  int         sel = 0;
  logic [7:0] mem [16];
  int         wr = 0;
  int         rd = 0;
  logic       flush;
  int         bad_deq = 0;
  int         vectors = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fifo_drain_uart_tx #(.CLOCK_FREQ(CF), .BAUD(BR), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_deq(deq0), .tx(tx0), .busy(busy0),
    .frame_done(fd0));

  fifo_drain_uart_tx #(.CLOCK_FREQ(CF), .BAUD(BR), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_deq(deq1), .tx(tx1), .busy(busy1),
    .frame_done(fd1));

  fifo_drain_uart_tx #(.CLOCK_FREQ(CF), .BAUD(BR), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_deq(deq2), .tx(tx2), .busy(busy2),
    .frame_done(fd2));

  assign fifo_empty = (rd == wr);
  assign fifo_dout  = mem[rd[3:0]];

  always_comb begin
    deq_s  = deq0;
    tx_s   = tx0;
    busy_s = busy0;
    fd_s   = fd0;
    if (sel == 1) begin
      deq_s = deq1; tx_s = tx1; busy_s = busy1; fd_s = fd1;
    end else if (sel == 2) begin
      deq_s = deq2; tx_s = tx2; busy_s = busy2; fd_s = fd2;
    end
  end

  always @(posedge clk) begin
    if (flush) rd <= wr;
    else if (deq_s && !fifo_empty) rd <= rd + 1;
    if ((deq0 || deq1 || deq2) && fifo_empty) bad_deq <= bad_deq + 1;
  end

  function automatic logic exp_tx(input logic [7:0] d, input int pm,
                                  input int k);
    int i;
    i = (k - 1) / 4;
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (pm != 0 && i == 9) return (pm == 2) ? ~(^d) : ^d;
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr[3:0]] = b;
    wr = wr + 1;
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    sel = s;
    rst = 1'b1;
    flush = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(0);
    #1;
    vectors++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || deq0 !== 1'b0 || fd0 !== 1'b0)
      begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b deq=%b fd=%b want 1 0 0 0",
               tx0, busy0, deq0, fd0);
    end
    vectors++;
    if (tx1 !== 1'b1 || tx2 !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0)
      begin
      errors++;
      $display("FAIL reset_par: tx1=%b tx2=%b busy1=%b busy2=%b want 1 1 0 0",
               tx1, tx2, busy1, busy2);
    end
  endtask

  task automatic test_single;
    do_reset(0);
    push(8'h55);
    #1;
    vectors++;
    if (deq_s !== 1'b1) begin
      errors++;
      $display("FAIL single_deq0: got %b want 1", deq_s);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      vectors++;
      if (tx_s !== exp_tx(8'h55, 0, k) || fd_s !== (k == 40) ||
          busy_s !== 1'b1 || deq_s !== 1'b0) begin
        errors++;
        $display("FAIL single k=%0d: tx=%b fd=%b busy=%b deq=%b want %b %b 1 0",
                 k, tx_s, fd_s, busy_s, deq_s, exp_tx(8'h55, 0, k), k == 40);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy_s !== 1'b0 || tx_s !== 1'b1) begin
      errors++;
      $display("FAIL single_end: busy=%b tx=%b want 0 1", busy_s, tx_s);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [3];
    int ndeq;
    int busyc;
    b[0] = 8'hA5; b[1] = 8'h00; b[2] = 8'hFF;
    ndeq = 0;
    busyc = 0;
    do_reset(0);
    push(b[0]); push(b[1]); push(b[2]);
    #1;
    for (int k = 0; k <= 121; k++) begin
      if (k > 0) @(negedge clk);
      if (deq_s === 1'b1) begin
        ndeq++;
        vectors++;
        if (k != 0 && k != 40 && k != 80) begin
          errors++;
          $display("FAIL b2b_deq_at: deq at cycle %0d want 0/40/80", k);
        end
      end
      if (k >= 1 && k <= 120) begin
        if (busy_s === 1'b1) busyc++;
        vectors++;
        if (tx_s !== exp_tx(b[(k-1)/40], 0, (k-1) % 40 + 1)) begin
          errors++;
          $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx_s,
                   exp_tx(b[(k-1)/40], 0, (k-1) % 40 + 1));
        end
      end
    end
    vectors++;
    if (ndeq != 3) begin
      errors++;
      $display("FAIL b2b_ndeq: got %0d want 3", ndeq);
    end
    vectors++;
    if (busyc != 120) begin
      errors++;
      $display("FAIL b2b_busy: high %0d cycles want 120", busyc);
    end
    vectors++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b want 0", busy_s);
    end
  endtask

  task automatic test_parity(input int pm);
    do_reset(pm);
    push(8'h07);
    #1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      vectors++;
      if (tx_s !== exp_tx(8'h07, pm, k) || fd_s !== (k == 44)) begin
        errors++;
        $display("FAIL par%0d k=%0d: tx=%b fd=%b want %b %b", pm, k,
                 tx_s, fd_s, exp_tx(8'h07, pm, k), k == 44);
      end
      if (k == 38) begin
        vectors++;
        if (tx_s !== (pm == 1)) begin
          errors++;
          $display("FAIL par%0d_bit: got %b want %b", pm, tx_s, pm == 1);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL par%0d_len: busy=%b at cycle 45 want 0", pm, busy_s);
    end
  endtask

  task automatic test_enable_drop;
    do_reset(0);
    push(8'h3C); push(8'h11); push(8'h22);
    #1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      vectors++;
      if (k <= 40) begin
        if (tx_s !== exp_tx(8'h3C, 0, k) || fd_s !== (k == 40) ||
            deq_s !== 1'b0) begin
          errors++;
          $display("FAIL endrop k=%0d: tx=%b fd=%b deq=%b want %b %b 0",
                   k, tx_s, fd_s, deq_s, exp_tx(8'h3C, 0, k), k == 40);
        end
      end else if (tx_s !== 1'b1 || busy_s !== 1'b0 || deq_s !== 1'b0) begin
        errors++;
        $display("FAIL endrop_idle k=%0d: tx=%b busy=%b deq=%b want 1 0 0",
                 k, tx_s, busy_s, deq_s);
      end
      if (k == 10) enable = 1'b0;
    end
    vectors++;
    if (wr - rd != 2) begin
      errors++;
      $display("FAIL endrop_left: %0d words left want 2", wr - rd);
    end
  endtask

  task automatic test_reset_midframe;
    do_reset(0);
    push(8'h96); push(8'h3C);
    #1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      vectors++;
      if (tx_s !== exp_tx(8'h96, 0, k)) begin
        errors++;
        $display("FAIL rstmid_pre k=%0d: got %b want %b", k, tx_s,
                 exp_tx(8'h96, 0, k));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (deq_s !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_deq: got %b want 0", deq_s);
    end
    @(negedge clk);
    vectors++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: tx=%b busy=%b want 1 0", tx_s, busy_s);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (deq_s !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_restart: deq=%b want 1", deq_s);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      vectors++;
      if (tx_s !== exp_tx(8'h3C, 0, k) || fd_s !== (k == 40)) begin
        errors++;
        $display("FAIL rstmid_post k=%0d: tx=%b fd=%b want %b %b", k,
                 tx_s, fd_s, exp_tx(8'h3C, 0, k), k == 40);
      end
    end
    vectors++;
    if (rd != wr) begin
      errors++;
      $display("FAIL rstmid_pops: %0d words left want 0", wr - rd);
    end
  endtask

  task automatic test_idle_empty;
    int bad;
    bad = 0;
    do_reset(0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (deq0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_empty: %0d bad cycles want 0", bad);
    end
    vectors++;
    if (bad_deq != 0) begin
      errors++;
      $display("FAIL deq_when_empty: %0d pops want 0", bad_deq);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_parity(1);
    test_parity(2);
    test_enable_drop;
    test_reset_midframe;
    test_idle_empty;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_uart_tx.md
FIFO_DRAIN_UART_TX -- requirements
Module: fifo_drain_uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 62500000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port enable  input  1  permits starting new frames.
REQ-007 SHALL have port fifo_empty  input  1  source FIFO holds no data.
REQ-008 SHALL have port fifo_dout  input  8  head word, valid combinationally while fifo_empty is low.
REQ-009 SHALL have port fifo_deq  output  1  single-cycle pop strobe to the FIFO.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  high from START through end of STOP.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on the last cycle of each STOP bit.

Function
REQ-013 SHALL use DIV = CLOCK_FREQ/BAUD, integer-truncated; DIV < 2 is an elaboration error.
REQ-014 SHALL hold each line bit for exactly DIV clock cycles, using a bit counter that runs 0..DIV-1.
REQ-015 SHALL implement the states IDLE, START, DATA, PAR and STOP.
REQ-016 In IDLE, when enable=1 and fifo_empty=0, SHALL capture fifo_dout, assert fifo_deq for that one cycle, and enter START on the next edge.
REQ-017 START SHALL drive tx=0; DATA SHALL drive 8 bits LSB first; PAR SHALL be present only when PARITY!=0; STOP SHALL drive tx=1.
REQ-018 Parity bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-019 Frame length SHALL be 10*DIV cycles with no parity and 11*DIV cycles with parity.
REQ-020 On the last STOP cycle, when enable=1 and fifo_empty=0, SHALL capture the next word and pulse fifo_deq, then enter START with zero idle cycles; otherwise SHALL enter IDLE.
REQ-021 fifo_deq SHALL never be asserted while fifo_empty=1, and SHALL pulse at most once per frame.
REQ-022 Deasserting enable mid-frame SHALL let the current frame complete, then stop without a further dequeue.
REQ-023 Changes to fifo_dout after capture SHALL NOT affect the frame in progress.
REQ-024 tx SHALL be registered (no combinational glitches).

Reset
REQ-025 On reset: tx=1, fifo_deq=0, busy=0, frame_done=0, state=IDLE, counters=0.
REQ-026 Reset mid-frame SHALL abort the frame, raise tx on the next edge, and discard the captured word without re-dequeue.

Structure
REQ-027 A shared package SHALL hold the state enum and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-028 The bit-period counter SHALL be a sub-module uart_baud_tick, which is restarted at frame start and emits a tick on count DIV-1.

Verification (CLOCK_FREQ=460800, BAUD=115200, so DIV=4)
REQ-029 Byte 0x55, PARITY=0, FIFO non-empty in IDLE -> fifo_deq high in that cycle; tx low from the next cycle; line pattern 0,1,0,1,0,1,0,1,0,1, 4 cycles each; frame_done at cycle 40.
REQ-030 Three words 0xA5, 0x00, 0xFF queued -> exactly 3 fifo_deq pulses 40 cycles apart; tx never high for more than 4 consecutive cycles between frames; busy continuously high for 120 cycles.
REQ-031 PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; frame length 44 cycles.
REQ-032 enable dropped at cycle 10 of the 0x3C frame with 2 words queued -> frame completes, no further fifo_deq, tx stays 1.
REQ-033 rst pulsed at cycle 17 of a frame -> tx=1 and busy=0 on the next edge; no fifo_deq during reset; the next word transmits normally afterward.
REQ-034 fifo_empty held high for 100 cycles -> fifo_deq never asserted, tx=1, busy=0 throughout.
